// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two byte-enabled
// write ports (port 1 wins on overlap), optional hardwired-zero entry 0 and
// optional write-to-read bypass. A sequencer zeroes the array one entry per
// cycle after reset and on clr_req, so the storage itself carries no reset.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_DEPTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 3,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    input  logic                         we0,
    input  logic [ADDR_WIDTH-1:0]        wa0,
    input  logic [DATA_WIDTH-1:0]        wd0,
    input  logic [DATA_WIDTH/8-1:0]      wbe0,
    input  logic                         we1,
    input  logic [ADDR_WIDTH-1:0]        wa1,
    input  logic [DATA_WIDTH-1:0]        wd1,
    input  logic [DATA_WIDTH/8-1:0]      wbe1,
    input  logic                         clr_req,
    output logic                         ready,
    output logic                         wr_drop
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    // One extra bit so ADDR_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(ADDR_DEPTH - 1);

    typedef enum logic [1:0] {StInit, StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    wr_drop_q, wr_drop_d;
    logic                    wr0_ok, wr1_ok;
    logic [DATA_WIDTH-1:0]   mem [ADDR_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DepthExt;
    endfunction

    assign ready   = (state_q == StReady);
    assign wr_drop = wr_drop_q;

    // A write really lands only when usable, in range and not aimed at the zero entry.
    assign wr0_ok = ready && we0 && in_range(wa0) && !(ZERO_REG && (wa0 == '0));
    assign wr1_ok = ready && we1 && in_range(wa1) && !(ZERO_REG && (wa1 == '0));

    // Stored value for one read address, merged with this cycle's writes when bypassing.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (ready && in_range(a) && !(ZERO_REG && (a == '0))) begin
            v = mem[a];
            if (BYPASS) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (wr0_ok && (wa0 == a) && wbe0[b]) v[b*8 +: 8] = wd0[b*8 +: 8];
                end
                for (int b = 0; b < NumBytes; b++) begin
                    if (wr1_ok && (wa1 == a) && wbe1[b]) v[b*8 +: 8] = wd1[b*8 +: 8];
                end
            end
        end
        return v;
    endfunction

    // Clear sequencer next state: walk idx over every entry, then open for use.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StInit, StClear: begin
                if (idx_q == LastIdx) begin
                    state_d = StReady;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StReady: begin
                if (clr_req) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                idx_d   = '0;
            end
        endcase
    end

    // Flag any write request that could not be honoured (not ready or out of range).
    always_comb begin
        wr_drop_d = (we0 && (!ready || !in_range(wa0))) ||
                    (we1 && (!ready || !in_range(wa1)));
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage: clearing writes while not ready, otherwise byte writes (port 1 issued last wins).
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[idx_q] <= '0;
        end else begin
            for (int b = 0; b < NumBytes; b++) begin
                if (wr0_ok && wbe0[b]) mem[wa0][b*8 +: 8] <= wd0[b*8 +: 8];
            end
            for (int b = 0; b < NumBytes; b++) begin
                if (wr1_ok && wbe1[b]) mem[wa1][b*8 +: 8] <= wd1[b*8 +: 8];
            end
        end
    end

    // Independent zero-latency read ports.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd[i*DATA_WIDTH +: DATA_WIDTH] = read_port(ra[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

endmodule
